// File: rtl/idct_pkg.sv
// Shared IDCT constants and types: plane/writeback enums, SRAM YUV layout and the 8-bit clip.
// Milestone-1 read addressing uses the same base and row-width constants.
package idct_pkg;

  typedef enum logic [1:0] {
    PLANE_Y = 2'd0,
    PLANE_U = 2'd1,
    PLANE_V = 2'd2
  } plane_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_RUN  = 2'd1,
    WB_DONE = 2'd2
  } wb_state_e;

  localparam int Y_BASE        = 0;
  localparam int U_BASE        = 38400;
  localparam int V_BASE        = 57600;
  localparam int Y_ROW_WORDS   = 160;
  localparam int UV_ROW_WORDS  = 80;
  localparam int Y_BLOCK_COLS  = 40;
  localparam int UV_BLOCK_COLS = 20;
  localparam int BLOCK_ROWS    = 30;
  localparam int BLOCK_WORDS   = 32;

  function automatic logic [7:0] clip8(input logic signed [15:0] v);
    if (v < 16'sd0)
      return 8'd0;
    else if (v > 16'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/wb_addr_gen.sv
// Block-walk address generator: c/r/bcol/brow/plane counters with an incremental
// SRAM word address (shift/add only, no multiplier).
module wb_addr_gen
  import idct_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        clear,
  input  logic        advance,
  output logic [17:0] address,
  output logic        last_in_block,
  output logic        last_in_frame
);

  plane_e      plane;
  logic [1:0]  c;
  logic [2:0]  r;
  logic [5:0]  bcol;
  logic [4:0]  brow;
  logic [17:0] brow_base;
  logic [17:0] row_base;
  logic [7:0]  col_off;

  logic [17:0] row_words;
  logic [5:0]  last_col;
  logic [17:0] next_plane_base;
  plane_e      next_plane;
  logic        col_last;
  logic        row_last;

  always_comb begin
    row_words       = (plane == PLANE_Y) ? 18'(Y_ROW_WORDS) : 18'(UV_ROW_WORDS);
    last_col        = (plane == PLANE_Y) ? 6'(Y_BLOCK_COLS - 1) : 6'(UV_BLOCK_COLS - 1);
    col_last        = (bcol == last_col);
    row_last        = (brow == 5'(BLOCK_ROWS - 1));
    next_plane      = PLANE_Y;
    next_plane_base = 18'(Y_BASE);
    case (plane)
      PLANE_Y: begin next_plane = PLANE_U; next_plane_base = 18'(U_BASE); end
      PLANE_U: begin next_plane = PLANE_V; next_plane_base = 18'(V_BASE); end
      default: begin next_plane = PLANE_Y; next_plane_base = 18'(Y_BASE); end
    endcase
    last_in_block = ({r, c} == 5'(BLOCK_WORDS - 1));
    last_in_frame = last_in_block && col_last && row_last && (plane == PLANE_V);
    address       = row_base + 18'(col_off) + 18'(c);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      plane     <= PLANE_Y;
      c         <= '0;
      r         <= '0;
      bcol      <= '0;
      brow      <= '0;
      brow_base <= 18'(Y_BASE);
      row_base  <= 18'(Y_BASE);
      col_off   <= '0;
    end else if (clear) begin
      plane     <= PLANE_Y;
      c         <= '0;
      r         <= '0;
      bcol      <= '0;
      brow      <= '0;
      brow_base <= 18'(Y_BASE);
      row_base  <= 18'(Y_BASE);
      col_off   <= '0;
    end else if (advance) begin
      if (c != 2'd3) begin
        c <= c + 2'd1;
      end else begin
        c <= '0;
        if (r != 3'd7) begin
          r        <= r + 3'd1;
          row_base <= row_base + row_words;
        end else begin
          r <= '0;
          // Block finished: return to the top row of the block-row, then step sideways/down/plane.
          if (!col_last) begin
            bcol     <= bcol + 6'd1;
            col_off  <= col_off + 8'd4;
            row_base <= brow_base;
          end else begin
            bcol    <= '0;
            col_off <= '0;
            if (!row_last) begin
              brow      <= brow + 5'd1;
              brow_base <= brow_base + (row_words << 3);
              row_base  <= brow_base + (row_words << 3);
            end else begin
              brow      <= '0;
              plane     <= next_plane;
              brow_base <= next_plane_base;
              row_base  <= next_plane_base;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/idct_sram_writeback.sv
// IDCT writeback: clips/packs pixel pairs and writes the Y/U/V frame to SRAM block by block.
// Optional WB_CHECKSUM_EN adds a rotate-xor checksum of all written words.
module idct_sram_writeback
  import idct_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_s_even,
  input  logic [15:0] in_s_odd,
  output logic        in_ready,
  input  logic        sram_grant,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        block_done,
  output logic        done
`ifdef WB_CHECKSUM_EN
  ,
  output logic [15:0] wb_checksum
`endif
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // RUN   | accepting pairs and issuing SRAM writes
  // DONE  | last V word written, done high until next start
  localparam logic [1:0] S_IDLE = WB_IDLE;
  localparam logic [1:0] S_RUN  = WB_RUN;
  localparam logic [1:0] S_DONE = WB_DONE;

  logic [1:0]  state;
  logic        out_full;
  logic        out_last_blk;
  logic        out_last_frame;
  logic        fed_all;
  logic        launch;
  logic        write_fire;
  logic        accept;
  logic [17:0] gen_address;
  logic        gen_last_blk;
  logic        gen_last_frame;

  always_comb begin
    launch     = start && (state != S_RUN);
    write_fire = out_full && sram_grant;
    in_ready   = (state == S_RUN) && !fed_all && (!out_full || write_fire);
    accept     = in_valid && in_ready;
    SRAM_we_n  = !write_fire;
    done       = (state == S_DONE);
  end

  wb_addr_gen u_addr_gen (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .clear        (launch),
    .advance      (accept),
    .address      (gen_address),
    .last_in_block(gen_last_blk),
    .last_in_frame(gen_last_frame)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      out_full        <= 1'b0;
      out_last_blk    <= 1'b0;
      out_last_frame  <= 1'b0;
      fed_all         <= 1'b0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      block_done      <= 1'b0;
    end else begin
      block_done <= write_fire && out_last_blk;
      if (launch) begin
        state    <= S_RUN;
        fed_all  <= 1'b0;
        out_full <= 1'b0;
      end else if (state == S_RUN) begin
        // A new pair may load in the same cycle the held word is written.
        if (accept) begin
          out_full        <= 1'b1;
          SRAM_address    <= gen_address;
          SRAM_write_data <= {clip8($signed(in_s_even)), clip8($signed(in_s_odd))};
          out_last_blk    <= gen_last_blk;
          out_last_frame  <= gen_last_frame;
          if (gen_last_frame)
            fed_all <= 1'b1;
        end else if (write_fire) begin
          out_full <= 1'b0;
        end
        if (write_fire && out_last_frame)
          state <= S_DONE;
      end
    end
  end

`ifdef WB_CHECKSUM_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      wb_checksum <= '0;
    else if (launch)
      wb_checksum <= '0;
    else if (write_fire)
      wb_checksum <= {wb_checksum[14:0], wb_checksum[15]} ^ SRAM_write_data;
  end
`endif

endmodule

// File: tb/tb_idct_sram_writeback.sv
// Scoreboard bench for idct_sram_writeback: expected words are queued on acceptance and
// checked on each SRAM write; includes a full frame with random grant drops.
module tb_idct_sram_writeback;

  logic        Clock;
  logic        Resetn;
  logic        start;
  logic        in_valid;
  logic [15:0] in_s_even;
  logic [15:0] in_s_odd;
  logic        in_ready;
  logic        sram_grant;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        block_done;
  logic        done;
`ifdef WB_CHECKSUM_EN
  logic [15:0] wb_checksum;
`endif

  idct_sram_writeback dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .start          (start),
    .in_valid       (in_valid),
    .in_s_even      (in_s_even),
    .in_s_odd       (in_s_odd),
    .in_ready       (in_ready),
    .sram_grant     (sram_grant),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .block_done     (block_done),
    .done           (done)
`ifdef WB_CHECKSUM_EN
    ,
    .wb_checksum    (wb_checksum)
`endif
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    logic        last_blk;
    int          idx;
  } sb_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   push_idx = 0;
  int   write_count = 0;
  int   bd_count = 0;
  int   cov_count = 0;
  int   dup_count = 0;
  int   first_addr = -1;
  int   first_u_addr = -1;
  int   first_v_addr = -1;
  logic exp_bd = 1'b0;
  logic exp_done = 1'b0;
  logic [15:0] mon_cs = '0;
  bit   cov [0:76799];
  bit   rand_en = 1'b0;
  bit   abort = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mclip(input logic [15:0] x);
    int s;
    s = int'($signed(x));
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return x[7:0];
  endfunction

  function automatic logic [17:0] addr_of(input int k);
    int base, rw, cols, kk, b, w;
    if (k < 38400) begin base = 0; rw = 160; cols = 40; kk = k; end
    else if (k < 57600) begin base = 38400; rw = 80; cols = 20; kk = k - 38400; end
    else begin base = 57600; rw = 80; cols = 20; kk = k - 57600; end
    b = kk / 32;
    w = kk % 32;
    return 18'(base + ((b / cols) * 8 + w / 4) * rw + (b % cols) * 4 + (w % 4));
  endfunction

  // Monitor: compare outputs first, then queue any pair the DUT accepts at the next edge.
  always @(negedge Clock) begin
    if (!Resetn) begin
      sb_q.delete();
      push_idx = 0; write_count = 0; bd_count = 0; cov_count = 0; dup_count = 0;
      exp_bd = 1'b0; exp_done = 1'b0; mon_cs = '0;
      first_addr = -1; first_u_addr = -1; first_v_addr = -1;
      foreach (cov[i]) cov[i] = 1'b0;
    end else begin
      chk("done_level", 32'(done), 32'(exp_done));
      chk("block_done_pulse", 32'(block_done), 32'(exp_bd));
      if (block_done) bd_count++;
      exp_bd = 1'b0;
      if (!SRAM_we_n) begin
        chk("write_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_t e;
          e = sb_q.pop_front();
          chk("wr_addr", 32'(SRAM_address), 32'(e.addr));
          chk("wr_data", 32'(SRAM_write_data), 32'(e.data));
          if (int'(SRAM_address) < 76800) begin
            if (cov[int'(SRAM_address)]) dup_count++;
            else begin cov[int'(SRAM_address)] = 1'b1; cov_count++; end
          end
          if (write_count == 0) first_addr = int'(SRAM_address);
          if (write_count == 38400) first_u_addr = int'(SRAM_address);
          if (write_count == 57600) first_v_addr = int'(SRAM_address);
          write_count++;
          exp_bd = e.last_blk;
          if (e.idx == 76799) exp_done = 1'b1;
          mon_cs = {mon_cs[14:0], mon_cs[15]} ^ e.data;
        end
      end
      if (in_valid && in_ready) begin
        sb_t n;
        n.addr     = addr_of(push_idx);
        n.data     = {mclip(in_s_even), mclip(in_s_odd)};
        n.last_blk = (push_idx % 32 == 31);
        n.idx      = push_idx;
        sb_q.push_back(n);
        push_idx++;
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
    if (rand_en) sram_grant = ($urandom_range(0, 63) != 0);
  endtask

  task automatic send_pair(input logic [15:0] e, input logic [15:0] o);
    bit ok;
    ok = 1'b0;
    if (abort) return;
    in_valid  = 1'b1;
    in_s_even = e;
    in_s_odd  = o;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge Clock);
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      abort = 1'b1;
      $error("FAIL send_timeout observed=in_ready_low expected=accept_within_200");
    end
  endtask

  task automatic send_rand();
    send_pair(16'(int'($urandom_range(0, 639)) - 192), 16'(int'($urandom_range(0, 639)) - 192));
  endtask

  initial begin
    Resetn = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_s_even = '0; in_s_odd = '0; sram_grant = 1'b1;
    #2 Resetn = 1'b0;
    step(); step();
    @(negedge Clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
    chk("rst_addr", 32'(SRAM_address), 32'd0);
    chk("rst_data", 32'(SRAM_write_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    Resetn = 1'b1;
    step();

    // in_valid while idle is ignored
    in_valid = 1'b1; in_s_even = 16'h0011; in_s_odd = 16'h0022;
    @(negedge Clock);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;

    start = 1'b1; step(); start = 1'b0;

    send_pair(16'h0012, 16'h0034);
    @(negedge Clock);
    chk("first_we_n", 32'(SRAM_we_n), 32'd0);
    chk("first_addr", 32'(SRAM_address), 32'd0);
    chk("first_data", 32'(SRAM_write_data), 32'h1234);
    step();
    send_pair(16'hFFFB, 16'd300);
    @(negedge Clock);
    chk("clip_neg_big", 32'(SRAM_write_data), 32'h00FF);
    step();
    send_pair(16'h00FF, 16'h0100);
    @(negedge Clock);
    chk("clip_255_256", 32'(SRAM_write_data), 32'hFFFF);
    step();

    for (int k = 3; k < 32; k++) begin
      if (k == 10) start = 1'b1;
      send_rand();
      start = 1'b0;
    end
    for (int n = 0; n < 50 && write_count < 32; n++) step();
    chk("block0_writes", 32'(write_count), 32'd32);
    step(); step();
    chk("block0_done_count", 32'(bd_count), 32'd1);

    send_pair(16'h0001, 16'h0002);
    @(negedge Clock);
    chk("block1_first_addr", 32'(SRAM_address), 32'd4);
    step();
    for (int k = 0; k < 5; k++) send_rand();

    // Grant withdrawn: the held word must stay put and no new pair may enter.
    sram_grant = 1'b0;
    in_valid = 1'b1; in_s_even = 16'h0055; in_s_odd = 16'h0066;
    for (int n = 0; n < 10; n++) begin
      @(negedge Clock);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_we_n", 32'(SRAM_we_n), 32'd1);
      chk("hold_queue", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) begin
        chk("hold_addr", 32'(SRAM_address), 32'(sb_q[0].addr));
        chk("hold_data", 32'(SRAM_write_data), 32'(sb_q[0].data));
      end
      step();
    end
    sram_grant = 1'b1;
    send_pair(16'h0055, 16'h0066);

    for (int k = 0; k < 600 && write_count < 500 && !abort; k++) send_rand();
    chk("reached_500", 32'(write_count >= 500), 32'd1);

    in_valid = 1'b0;
    Resetn = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_we_n", 32'(SRAM_we_n), 32'd1);
    chk("midrst_addr", 32'(SRAM_address), 32'd0);
    chk("midrst_data", 32'(SRAM_write_data), 32'd0);
    chk("midrst_block_done", 32'(block_done), 32'd0);
    step(); step();
    Resetn = 1'b1;
    step();

    // Full frame with random grant drops
    start = 1'b1; step(); start = 1'b0;
    rand_en = 1'b1;
    for (int k = 0; k < 76800 && !abort; k++) send_rand();
    rand_en = 1'b0;
    sram_grant = 1'b1;
    for (int n = 0; n < 200 && !done; n++) step();
    @(negedge Clock);
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_writes", 32'(write_count), 32'd76800);
    chk("frame_coverage", 32'(cov_count), 32'd76800);
    chk("frame_dups", 32'(dup_count), 32'd0);
    chk("frame_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("frame_first_addr", 32'(first_addr), 32'd0);
    chk("frame_first_u", 32'(first_u_addr), 32'd38400);
    chk("frame_first_v", 32'(first_v_addr), 32'd57600);
`ifdef WB_CHECKSUM_EN
    chk("frame_checksum", 32'(wb_checksum), 32'(mon_cs));
`endif
    step();

    in_valid = 1'b1;
    @(negedge Clock);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idct_sram_writeback.md
Name: idct_sram_writeback

Overview:
- Final stage of the milestone-2 IDCT datapath; upstream neighbour of the milestone-1 upsample/CSC engine.
- Takes reconstructed 8x8 pixel blocks as pixel pairs from the S-computation stage.
- Clips each value to 8 bits, packs two pixels per 16-bit word and writes the words to the YUV region of external SRAM.
- Walks all Y, then U, then V blocks in raster order, with block-to-SRAM address mapping.

Parameters:
- Y_BASE, 0, word address of first Y word
- U_BASE, 38400, word address of first U word
- V_BASE, 57600, word address of first V word
- Y_ROW_WORDS, 160, SRAM words per Y image row (320 px)
- UV_ROW_WORDS, 80, SRAM words per U/V image row (160 px)
- Y_BLOCK_COLS, 40, 8x8 blocks per Y block-row
- UV_BLOCK_COLS, 20, 8x8 blocks per U/V block-row
- BLOCK_ROWS, 30, block-rows per plane

Ports:
- Clock  in  1  system clock (50 MHz)
- Resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a full-frame writeback
- in_valid  in  1  pixel pair available
- in_s_even  in  16  signed pixel value, even column
- in_s_odd  in  16  signed pixel value, odd column
- in_ready  out  1  pair accepted when in_valid && in_ready
- sram_grant  in  1  SRAM port owned by this block this cycle
- SRAM_address  out  18  write address
- SRAM_write_data  out  16  {clip(even), clip(odd)}
- SRAM_we_n  out  1  active-low write enable
- block_done  out  1  one-cycle pulse after the 32nd word of a block is written
- done  out  1  level; high after the last V word, until next start

Behaviour:
- Interface: one clock, Clock. Reset Resetn is asynchronous and active-low.
- Reset values:
  - State IDLE; all counters 0.
  - in_ready=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
  - block_done=0, done=0.
- States:
  - IDLE: start -> RUN; clears done and counters.
  - RUN: accept pairs, issue writes.
  - DONE: done=1; start -> RUN.
- Handshake:
  - in_ready = (state==RUN) && (!out_reg_full || (sram_grant && write issuing this cycle)).
  - Single output register stage. A pair accepted in cycle N drives SRAM_we_n=0 in cycle N+1 if sram_grant=1 in N+1.
  - Otherwise the write holds stable (address, data, we_n=1) until the grant cycle.
  - SRAM_we_n=0 only when sram_grant=1 and the register is full.
- Clip: value<0 -> 0; value>255 -> 255; else [7:0]. Even pixel goes in [15:8], odd in [7:0].
- Order within a block: c=0..3 (word in row), then r=0..7.
- Address = plane_base + (brow*8 + r)*ROW_WORDS + bcol*4 + c.
  - Computed incrementally: row_base register += ROW_WORDS; block-column offset += 4.
  - No multiplier in the datapath.
- Block advance:
  - bcol increments; at BLOCK_COLS-1 it wraps to 0 and brow increments.
  - At brow=29 wrap: plane Y->U->V.
  - After V block (29,19) r=7 c=3 is written -> DONE.
  - Total 76800 writes; last address 76799.
- block_done pulses in the cycle after the last word's write cycle.
- Boundaries:
  - in_valid while IDLE/DONE is ignored (in_ready=0).
  - start while RUN is ignored.
  - Grant withdrawn mid-block: hold, lose nothing.
  - Resetn mid-frame: immediate return to reset values; partial frame abandoned.

Optional Feature:
- WB_CHECKSUM_EN
- Defined: adds output wb_checksum[15:0]. It is cleared on start, and on each write cycle it is updated as (checksum rotated left 1) XOR SRAM_write_data. The value is stable when done=1.
- Undefined: no port, no logic.

Decomposition:
- Shared package idct_pkg:
  - plane enum (PLANE_Y, PLANE_U, PLANE_V)
  - writeback state enum
  - base/row-width constants, also used by milestone-1 read addressing
  - BLOCK_WORDS=32
- Natural sub-module: wb_addr_gen. Owns the c/r/bcol/brow/plane counters and the incremental address. Exposes advance, address, last_in_block, last_in_frame.

Test Plan:
- Reset, start, first pair (0x0012, 0x0034), grant=1 -> cycle+1: we_n=0, address 0, data 0x1234.
- Pairs (-5, 300) and (0x00FF, 0x0100) -> data 0x00FF and 0xFFFF.
- Stream 32 pairs -> addresses 0..3, 160..163, ..., 1120..1123; block_done once. Next block's first word goes to address 4.
- Full frame with random grant drops -> exactly 76800 writes, each address 0..76799 written once. First U write at 38400, first V write at 57600; done=1 after the 76799 write.
- Grant low for 10 cycles mid-block -> address/data held, in_ready=0 after the register fills; no duplicate or missing write.
- Resetn asserted at write #500 -> outputs reset immediately. Restart writes address 0 first.
